// File: rtl/compl_pkg.sv
// Shared encodings for the serial complementer: operation modes and FSM states.
package compl_pkg;

  typedef enum logic [1:0] {
    MODE_NEG  = 2'b00,
    MODE_ONES = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/compl_digit.sv
// One DIGIT-wide slice of the complementer: optional inversion plus carry-in add.
module compl_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] op,
  input  logic             inv,
  input  logic             cin,
  output logic [DIGIT-1:0] res,
  output logic             cout
);

  logic [DIGIT:0] sum;

  assign sum         = {1'b0, op ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, cin};
  assign {cout, res} = sum;

endmodule

// File: rtl/complement_serial.sv
// Digit-serial negate / one's complement / abs / pass-through, DIGIT bits per cycle.
// Define COMPL_OVF_EN to build the overflow flag for negating the most negative operand.
module complement_serial
  import compl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, inv_q;
  logic [WIDTH-1:0] op_q;
  logic [DIGIT-1:0] op_k, res_k;
  logic             cout_k;
  logic             accept, last_dig;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign last_dig  = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_BUSY;
      ST_BUSY: if (last_dig)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_k = '0;
    for (int k = 0; k < NDIG; k++)
      if (cnt_q == CNT_W'(k)) op_k = op_q[k*DIGIT +: DIGIT];
  end

  compl_digit #(.DIGIT(DIGIT)) u_digit (
    .op   (op_k),
    .inv  (inv_q),
    .cin  (carry_q),
    .res  (res_k),
    .cout (cout_k)
  );

  // Operand capture: pure data, only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) op_q <= in_data;
  end

  // Digit sequencing: carry chains between cycles, final carry-out is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      inv_q    <= 1'b0;
      out_data <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      case (in_mode)
        MODE_NEG:  begin inv_q <= 1'b1;             carry_q <= 1'b1;             end
        MODE_ONES: begin inv_q <= 1'b1;             carry_q <= 1'b0;             end
        MODE_ABS:  begin inv_q <= in_data[WIDTH-1]; carry_q <= in_data[WIDTH-1]; end
        default:   begin inv_q <= 1'b0;             carry_q <= 1'b0;             end
      endcase
    end else if (state_q == ST_BUSY) begin
      for (int k = 0; k < NDIG; k++)
        if (cnt_q == CNT_W'(k)) out_data[k*DIGIT +: DIGIT] <= res_k;
      carry_q <= cout_k;
      cnt_q   <= last_dig ? '0 : cnt_q + CNT_W'(1);
    end
  end

`ifdef COMPL_OVF_EN
  localparam logic [DIGIT-1:0] LAST_MASK = {DIGIT{1'b1}} >> 1;

  mode_e            mode_q;
  logic             lowz_q;
  logic [DIGIT-1:0] low_bits;

  // The MSB itself is excluded from the zero test on the top digit.
  assign low_bits = op_k & (last_dig ? LAST_MASK : {DIGIT{1'b1}});

  always_ff @(posedge clk) begin
    if (accept) mode_q <= mode_e'(in_mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lowz_q  <= 1'b1;
      out_ovf <= 1'b0;
    end else if (accept) begin
      lowz_q  <= 1'b1;
      out_ovf <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      lowz_q <= lowz_q && (low_bits == '0);
      if (last_dig)
        out_ovf <= op_q[WIDTH-1] && lowz_q && (low_bits == '0) &&
                   ((mode_q == MODE_NEG) || (mode_q == MODE_ABS));
    end
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_complement_serial.sv
// Directed bench for complement_serial with DIGIT = 8, 1 and 32 instances.
module tb_complement_serial;
  import compl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic        orr[3];
  logic        ovf[3];
  logic [31:0] id [3];
  logic [31:0] od [3];
  logic [1:0]  im [3];

  int n_chk  = 0;
  int n_pass = 0;

`ifdef COMPL_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  complement_serial #(.WIDTH(32), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .in_mode(im[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .out_ovf(ovf[0]));

  complement_serial #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .in_mode(im[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .out_ovf(ovf[1]));

  complement_serial #(.WIDTH(32), .DIGIT(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .in_mode(im[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .out_ovf(ovf[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_op(input int u, input logic [1:0] m, input logic [31:0] d,
                        input logic [31:0] ed, input logic eo, input int elat,
                        input bit hs, input string tag);
    int lat;
    @(negedge clk);
    id[u] = d; im[u] = m; iv[u] = 1'b1;
    @(negedge clk);
    iv[u] = 1'b0; id[u] = '0;
    lat = 0;
    while (!ov[u] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"},  64'(lat),    64'(elat));
    chk({tag, "_data"}, 64'(od[u]),  64'(ed));
    chk({tag, "_ovf"},  64'(ovf[u]), 64'(eo));
    if (hs) begin
      orr[u] = 1'b1;
      @(negedge clk);
      orr[u] = 1'b0;
      chk({tag, "_rdy_after"}, 64'(ir[u]), 64'd1);
      chk({tag, "_vld_after"}, 64'(ov[u]), 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b0; id[i] = '0; im[i] = 2'b00;
    end
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(ir[0]),  64'd1);
    chk("rst_out_valid", 64'(ov[0]),  64'd0);
    chk("rst_out_data",  64'(od[0]),  64'd0);
    chk("rst_out_ovf",   64'(ovf[0]), 64'd0);
    rst_n = 1'b1;

    run_op(0, MODE_NEG,  32'h0000_0234, 32'hFFFF_FDCC, 1'b0,    4, 1'b1, "neg234");
    run_op(0, MODE_ONES, 32'h0000_0EFF, 32'hFFFF_F100, 1'b0,    4, 1'b1, "ones");
    run_op(0, MODE_PASS, 32'h0000_0EFF, 32'h0000_0EFF, 1'b0,    4, 1'b1, "pass");
    run_op(0, MODE_ABS,  32'hFFFF_FDCC, 32'h0000_0234, 1'b0,    4, 1'b1, "abs_neg");
    run_op(0, MODE_ABS,  32'h0000_0234, 32'h0000_0234, 1'b0,    4, 1'b1, "abs_pos");
    run_op(0, MODE_NEG,  32'h8000_0000, 32'h8000_0000, OVF_EXP, 4, 1'b1, "neg_min");
    run_op(0, MODE_ABS,  32'h8000_0000, 32'h8000_0000, OVF_EXP, 4, 1'b1, "abs_min");
    run_op(0, MODE_ONES, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0,    4, 1'b1, "ones_min");
    run_op(0, MODE_NEG,  32'h8000_0100, 32'h7FFF_FF00, 1'b0,    4, 1'b1, "neg_nearmin");
    run_op(0, MODE_NEG,  32'h0000_0000, 32'h0000_0000, 1'b0,    4, 1'b1, "neg_zero");

    // Back-pressure: result held, new requests refused
    run_op(0, MODE_NEG, 32'h0000_0234, 32'hFFFF_FDCC, 1'b0, 4, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1; id[0] = 32'h1111_1111; im[0] = MODE_PASS;
      @(negedge clk);
      chk("bp_hold_data", 64'(od[0]), 64'hFFFF_FDCC);
      chk("bp_in_ready",  64'(ir[0]), 64'd0);
      chk("bp_out_valid", 64'(ov[0]), 64'd1);
    end
    iv[0] = 1'b0;
    orr[0] = 1'b1;
    @(negedge clk);
    orr[0] = 1'b0;
    chk("bp_rel_in_ready",  64'(ir[0]), 64'd1);
    chk("bp_rel_out_valid", 64'(ov[0]), 64'd0);

    // Reset during the second BUSY cycle
    @(negedge clk);
    id[0] = 32'h0000_0005; im[0] = MODE_NEG; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(od[0] == 32'h0 ? ov[0] : 1'b1), 64'd0);
    chk("abort_out_data",  64'(od[0]), 64'd0);
    chk("abort_in_ready",  64'(ir[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_rel_in_ready", 64'(ir[0]), 64'd1);
    run_op(0, MODE_NEG, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 4, 1'b1, "post_rst");

    run_op(1, MODE_NEG, 32'h0000_0234, 32'hFFFF_FDCC, 1'b0,    32, 1'b1, "d1_neg234");
    run_op(1, MODE_NEG, 32'h8000_0000, 32'h8000_0000, OVF_EXP, 32, 1'b1, "d1_neg_min");
    run_op(2, MODE_NEG, 32'h0000_0234, 32'hFFFF_FDCC, 1'b0,    1,  1'b1, "d32_neg234");
    run_op(2, MODE_NEG, 32'h8000_0000, 32'h8000_0000, OVF_EXP, 1,  1'b1, "d32_neg_min");
    run_op(2, MODE_ABS, 32'hFFFF_FDCC, 32'h0000_0234, 1'b0,    1,  1'b1, "d32_abs");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
